// File: rtl/ttu_pkg.sv
// Shared types and default timing for the target tracking unit.
// Optional echo capture is built only when TTU_ECHO_LATCH_EN is defined.
package ttu_pkg;

  typedef enum logic [1:0] {
    TTU_IDLE     = 2'b00,
    TTU_TRANSMIT = 2'b01,
    TTU_LISTEN   = 2'b10,
    TTU_TRACK    = 2'b11
  } ttu_state_e;

  localparam int unsigned TTU_CLK_PERIOD_US = 10;
  localparam int unsigned TTU_TRANSMIT_US   = 50;
  localparam int unsigned TTU_LISTEN_US     = 100;
  localparam int unsigned TTU_TRACK_US      = 300;
  localparam int unsigned TTU_M_PER_US      = 150;

  localparam int unsigned DIST_W = 14;

  // Width of one counter able to time the longest of the three phases.
  function automatic int unsigned ttu_cnt_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ttu_echo_capture.sv
// Catches sub-cycle echo pulses with a toggle flop and flags them in the clk domain.
// Instantiated only when TTU_ECHO_LATCH_EN is defined.
module ttu_echo_capture (
  input  logic clk,
  input  logic echo_i,
  output logic echo_event_o
);

  logic toggle_q = 1'b0;
  logic mirror_q;

  always_ff @(posedge echo_i) begin
    toggle_q <= ~toggle_q;
  end

  // The mirror realigns on every clk edge, which also covers reset, so any
  // echo seen outside the listen window is dropped after one cycle.
  always_ff @(posedge clk) begin
    mirror_q <= toggle_q;
  end

  assign echo_event_o = toggle_q ^ mirror_q;

endmodule

// File: rtl/target_tracking_unit.sv
// Radar target tracker: fire pulse, listen for echo, convert to range, hold lock.
// Define TTU_ECHO_LATCH_EN to capture echo pulses shorter than one clock.
module target_tracking_unit
  import ttu_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_US = TTU_CLK_PERIOD_US,
  parameter int unsigned TRANSMIT_US   = TTU_TRANSMIT_US,
  parameter int unsigned LISTEN_US     = TTU_LISTEN_US,
  parameter int unsigned TRACK_US      = TTU_TRACK_US,
  parameter int unsigned M_PER_US      = TTU_M_PER_US
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              track_target_command,
  input  logic              echo,
  output logic              trigger_radar_transmitter,
  output logic [DIST_W-1:0] distance_to_target,
  output logic              target_locked,
  output logic [1:0]        TTU_state
);

  localparam logic [1:0] S_IDLE     = TTU_IDLE;
  localparam logic [1:0] S_TRANSMIT = TTU_TRANSMIT;
  localparam logic [1:0] S_LISTEN   = TTU_LISTEN;
  localparam logic [1:0] S_TRACK    = TTU_TRACK;

  localparam int unsigned TX_CYC     = TRANSMIT_US / CLK_PERIOD_US;
  localparam int unsigned LISTEN_CYC = LISTEN_US / CLK_PERIOD_US;
  localparam int unsigned TRACK_CYC  = TRACK_US / CLK_PERIOD_US;
  localparam int unsigned M_PER_CYC  = CLK_PERIOD_US * M_PER_US;
  localparam int unsigned CNT_W      = ttu_cnt_width(TX_CYC, LISTEN_CYC, TRACK_CYC);

  localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(TX_CYC - 1);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYC - 1);
  localparam logic [CNT_W-1:0] TRACK_LAST  = CNT_W'(TRACK_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              lock_q, lock_d;
  logic              trig_q;
  logic              echo_event;

`ifdef TTU_ECHO_LATCH_EN
  ttu_echo_capture u_echo_capture (
    .clk          (clk),
    .echo_i       (echo),
    .echo_event_o (echo_event)
  );
`else
  assign echo_event = echo;
`endif

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    dist_d  = dist_q;
    lock_d  = lock_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (track_target_command) state_d = S_TRANSMIT;
      end
      S_TRANSMIT: begin
        if (cnt_q == TX_LAST) begin
          state_d = S_LISTEN;
          cnt_d   = '0;
        end
      end
      S_LISTEN: begin
        // cnt_q + 1 is the edge index since entry; echo wins over timeout.
        if (echo_event) begin
          dist_d  = DIST_W'((32'(cnt_q) + 32'd1) * M_PER_CYC);
          lock_d  = 1'b1;
          state_d = S_TRACK;
          cnt_d   = '0;
        end else if (cnt_q == LISTEN_LAST) begin
          dist_d  = '0;
          lock_d  = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_TRACK: begin
        if (track_target_command) begin
          state_d = S_TRANSMIT;
          cnt_d   = '0;
        end else if (cnt_q == TRACK_LAST) begin
          dist_d  = '0;
          lock_d  = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
      lock_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      lock_q  <= lock_d;
      trig_q  <= (state_d == S_TRANSMIT);
    end
  end

  assign trigger_radar_transmitter = trig_q;
  assign distance_to_target        = dist_q;
  assign target_locked             = lock_q;
  assign TTU_state                 = state_q;

endmodule

// File: tb/tb_target_tracking_unit.sv
// Self-checking bench for target_tracking_unit: directed sequence plus random
// stimulus against a phase/countdown reference model.
`timescale 1us/100ns
module tb_target_tracking_unit;

  localparam int TX_CYC     = 50 / 10;
  localparam int LISTEN_CYC = 100 / 10;
  localparam int TRACK_CYC  = 300 / 10;
  localparam int M_PER_EDGE = 10 * 150;

`ifdef TTU_ECHO_LATCH_EN
  localparam bit SUB_OK = 1'b1;
`else
  localparam bit SUB_OK = 1'b0;
`endif

  typedef enum logic [1:0] {
    M_IDLE = 2'b00, M_TX = 2'b01, M_LISTEN = 2'b10, M_TRACK = 2'b11
  } phase_e;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        track_target_command = 1'b0;
  logic        echo = 1'b0;
  logic        trigger_radar_transmitter;
  logic [13:0] distance_to_target;
  logic        target_locked;
  logic [1:0]  TTU_state;

  int n_tests = 0;
  int n_fail  = 0;

  phase_e m_phase = M_IDLE;
  int     m_remain = 0;
  int     m_k = 0;
  int     m_dist = 0;
  bit     m_lock = 1'b0;

  target_tracking_unit dut (
    .clk                       (clk),
    .rst                       (rst),
    .track_target_command      (track_target_command),
    .echo                      (echo),
    .trigger_radar_transmitter (trigger_radar_transmitter),
    .distance_to_target        (distance_to_target),
    .target_locked             (target_locked),
    .TTU_state                 (TTU_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // One rising edge of the reference: phases, remaining cycles and listen index.
  task automatic model_edge(input bit cmd, input bit r, input bit ev);
    if (r) begin
      m_phase = M_IDLE; m_dist = 0; m_lock = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE:
          if (cmd) begin m_phase = M_TX; m_remain = TX_CYC; end
        M_TX: begin
          m_remain--;
          if (m_remain == 0) begin m_phase = M_LISTEN; m_k = 0; end
        end
        M_LISTEN: begin
          m_k++;
          if (ev) begin
            m_dist = m_k * M_PER_EDGE; m_lock = 1'b1;
            m_phase = M_TRACK; m_remain = TRACK_CYC;
          end else if (m_k == LISTEN_CYC) begin
            m_dist = 0; m_lock = 1'b0; m_phase = M_IDLE;
          end
        end
        M_TRACK: begin
          if (cmd) begin
            m_phase = M_TX; m_remain = TX_CYC;
          end else begin
            m_remain--;
            if (m_remain == 0) begin m_dist = 0; m_lock = 1'b0; m_phase = M_IDLE; end
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  // Called half a cycle before a rising edge; returns half a cycle after it.
  // An echo rises 3 us before the edge and either straddles it or, when
  // sub is set, falls again 2 us before the edge.
  task automatic step(input bit cmd, input bit r, input bit ev, input bit sub);
    rst = r;
    track_target_command = cmd;
    #2;
    if (ev) echo = 1'b1;
    #1;
    if (sub) echo = 1'b0;
    @(posedge clk);
    model_edge(cmd, r, ev);
    #2 echo = 1'b0;
    @(negedge clk);
    check("state",    32'(TTU_state),                 32'(m_phase));
    check("trigger",  32'(trigger_radar_transmitter), 32'(m_phase == M_TX));
    check("distance", 32'(distance_to_target),        32'(m_dist));
    check("locked",   32'(target_locked),             32'(m_lock));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, SUB_OK);
    idle(1);

    // Basic acquisition at k=3 then lock expiry.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TX_CYC + 2);
    step(1'b0, 1'b0, 1'b1, SUB_OK);
    check("dist_k3", 32'(distance_to_target), 32'd4500);
    idle(TRACK_CYC + 1);

    // No echo: listen window times out.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TX_CYC + LISTEN_CYC);
    check("timeout_idle", 32'(TTU_state), 32'd0);

    // Lock refresh during TRACK.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TX_CYC + 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TX_CYC + 1);
    check("refresh_lock", 32'(target_locked), 32'd1);
    step(1'b0, 1'b0, 1'b1, SUB_OK);
    check("dist_k2", 32'(distance_to_target), 32'd3000);

    // Echoes in TRACK and TRANSMIT are discarded.
    step(1'b0, 1'b0, 1'b1, SUB_OK);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, SUB_OK);
    idle(TX_CYC - 1 + LISTEN_CYC);
    check("ignored_idle", 32'(TTU_state), 32'd0);
    check("ignored_lock", 32'(target_locked), 32'd0);

    // Echo on the final listen edge beats the timeout.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TX_CYC + LISTEN_CYC - 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("dist_k10", 32'(distance_to_target), 32'd15000);

    // Reset mid-listen, then a late echo.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TX_CYC + 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, SUB_OK);
    check("rst_dist", 32'(distance_to_target), 32'd0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      bit cmd, r, ev, sub;
      cmd = ($urandom_range(0, 11) == 0);
      r   = ($urandom_range(0, 299) == 0);
      ev  = (m_phase == M_LISTEN) ? ($urandom_range(0, 5) == 0)
                                  : ($urandom_range(0, 9) == 0);
      sub = ev && SUB_OK && ($urandom_range(0, 1) == 1);
      step(cmd, r, ev, sub);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
